// File: rtl/add_sub_pkg.sv
// Shared encodings for the chunked add/subtract unit.
package add_sub_pkg;

  localparam int unsigned OP_W = 2;

  // Operation select: bit 1 selects subtraction (invert B), bit 0 uses CIN.
  typedef enum logic [OP_W-1:0] {
    OP_ADD = 2'b00,
    OP_ADC = 2'b01,
    OP_SUB = 2'b10,
    OP_SBB = 2'b11
  } op_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_e;

endpackage

// File: rtl/add_chunk.sv
// One CHUNK-bit slice of the ripple adder; also exposes the carry into its top bit.
module add_chunk #(
  parameter int unsigned CHUNK = 4
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  input  logic             cin,
  output logic [CHUNK-1:0] s,
  output logic             cout,
  output logic             c_msb
);

  logic [CHUNK:0] total;

  // Slice sum; carry into the top bit recovered from the top-bit sum equation.
  always_comb begin
    total = (CHUNK+1)'(a) + (CHUNK+1)'(b) + (CHUNK+1)'(cin);
    s     = total[CHUNK-1:0];
    cout  = total[CHUNK];
    c_msb = a[CHUNK-1] ^ b[CHUNK-1] ^ total[CHUNK-1];
  end

endmodule

// File: rtl/add_sub_chunked.sv
// Multi-cycle add/subtract: processes CHUNK bits per clock, result after WIDTH/CHUNK cycles.
module add_sub_chunked
  import add_sub_pkg::*;
#(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned CHUNK = 4   // WIDTH must be a multiple of CHUNK
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cs,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             CIN,
  input  logic [1:0]       OP,
  output logic [WIDTH-1:0] SUM,
  output logic             COUT,
  output logic             OVF,
  output logic             ZERO,
  output logic             NEG,
  output logic             rdy,
  output logic             done
);

  localparam int unsigned NCHUNK = WIDTH / CHUNK;
  localparam int unsigned IDXW   = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

  state_e            state_q, state_d;
  logic [WIDTH-1:0]  a_q, b_q, res_q;
  logic              carry_q;
  logic [IDXW-1:0]   idx_q;

  logic [CHUNK-1:0]  s_c;
  logic              cout_c, c_msb_c;
  logic [WIDTH-1:0]  res_c;
  logic              accept_c, last_c, init_carry_c;

  // Operands are shifted right each cycle so the slice always reads the low chunk.
  add_chunk #(.CHUNK(CHUNK)) u_chunk (
    .a     (a_q[CHUNK-1:0]),
    .b     (b_q[CHUNK-1:0]),
    .cin   (carry_q),
    .s     (s_c),
    .cout  (cout_c),
    .c_msb (c_msb_c)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // Next state, accept/finish strobes and the partial result with this chunk shifted in.
  always_comb begin
    state_d  = state_q;
    accept_c = 1'b0;
    last_c   = 1'b0;
    res_c    = (res_q >> CHUNK) | (WIDTH'(s_c) << (WIDTH - CHUNK));
    case (state_q)
      ST_IDLE: begin
        if (cs) begin
          accept_c = 1'b1;
          state_d  = ST_BUSY;
        end
      end
      ST_BUSY: begin
        if (idx_q == IDXW'(NCHUNK - 1)) begin
          last_c  = 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Initial carry per operation; SBB borrows by feeding the inverted CIN.
  always_comb begin
    init_carry_c = 1'b0;
    case (op_e'(OP))
      OP_ADD:  init_carry_c = 1'b0;
      OP_ADC:  init_carry_c = CIN;
      OP_SUB:  init_carry_c = 1'b1;
      OP_SBB:  init_carry_c = ~CIN;
      default: init_carry_c = 1'b0;
    endcase
  end

  // Operand capture, per-chunk accumulation and result/flag update on the last chunk.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      carry_q <= 1'b0;
      idx_q   <= '0;
      SUM     <= '0;
      COUT    <= 1'b0;
      OVF     <= 1'b0;
      ZERO    <= 1'b0;
      NEG     <= 1'b0;
      rdy     <= 1'b1;
      done    <= 1'b0;
    end else begin
      done <= 1'b0;
      if (accept_c) begin
        a_q     <= A;
        b_q     <= OP[1] ? ~B : B;
        carry_q <= init_carry_c;
        res_q   <= '0;
        idx_q   <= '0;
        rdy     <= 1'b0;
      end else if (state_q == ST_BUSY) begin
        a_q     <= a_q >> CHUNK;
        b_q     <= b_q >> CHUNK;
        carry_q <= cout_c;
        res_q   <= res_c;
        idx_q   <= idx_q + IDXW'(1);
        if (last_c) begin
          SUM   <= res_c;
          COUT  <= cout_c;
          OVF   <= c_msb_c ^ cout_c;
          ZERO  <= (res_c == '0);
          NEG   <= res_c[WIDTH-1];
          done  <= 1'b1;
          rdy   <= 1'b1;
          idx_q <= '0;
        end
      end
    end
  end

endmodule

// File: tb/tb_add_sub_chunked.sv
// Directed self-checking bench for add_sub_chunked (WIDTH=16, CHUNK=4).
module tb_add_sub_chunked;

  logic        clk = 1'b0;
  logic        rst;
  logic        cs;
  logic [15:0] A, B;
  logic        CIN;
  logic [1:0]  OP;
  logic [15:0] SUM;
  logic        COUT, OVF, ZERO, NEG, rdy, done;

  int n_tests = 0;
  int n_fail  = 0;
  int lat, busy, ndone;

  add_sub_chunked #(.WIDTH(16), .CHUNK(4)) dut (
    .clk  (clk),
    .rst  (rst),
    .cs   (cs),
    .A    (A),
    .B    (B),
    .CIN  (CIN),
    .OP   (OP),
    .SUM  (SUM),
    .COUT (COUT),
    .OVF  (OVF),
    .ZERO (ZERO),
    .NEG  (NEG),
    .rdy  (rdy),
    .done (done)
  );

  always #5 clk = ~clk;

  // Advance one edge; drive and sample 1 ns after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_res(input string tag, input logic [15:0] s, input logic co,
                         input logic ov, input logic z, input logic n);
    chk({tag, ".sum"},  32'(SUM),  32'(s));
    chk({tag, ".cout"}, 32'(COUT), 32'(co));
    chk({tag, ".ovf"},  32'(OVF),  32'(ov));
    chk({tag, ".zero"}, 32'(ZERO), 32'(z));
    chk({tag, ".neg"},  32'(NEG),  32'(n));
  endtask

  // Present an operation and clock the accepting edge.
  task automatic start_op(input logic [15:0] a, input logic [15:0] b,
                          input logic c, input logic [1:0] op);
    A = a; B = b; CIN = c; OP = op; cs = 1'b1;
    step();
    cs = 1'b0;
  endtask

  // Wait (bounded) for done; optionally pulse cs and scramble operands while busy.
  task automatic wait_done(input bit poke);
    lat = 0; busy = 0;
    while (lat < 20) begin
      if (rdy === 1'b0) busy++;
      step();
      lat++;
      if (done === 1'b1) break;
      cs = (poke && lat <= 2);
      if (poke) begin
        A = 16'($urandom); B = 16'($urandom);
        CIN = 1'($urandom); OP = 2'($urandom);
      end
    end
    cs = 1'b0;
  endtask

  // Count done pulses over n idle cycles.
  task automatic idle_cycles(input int n);
    ndone = 0;
    for (int i = 0; i < n; i++) begin
      step();
      if (done === 1'b1) ndone++;
    end
  endtask

  initial begin
    rst = 1'b1; cs = 1'b1; A = 16'hAAAA; B = 16'h5555; CIN = 1'b0; OP = 2'b00;
    step();
    step();
    // Reset state, with cs held high throughout
    chk_res("reset", 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("reset.rdy",  32'(rdy),  32'd1);
    chk("reset.done", 32'(done), 32'd0);
    rst = 1'b0; cs = 1'b0;
    step();
    chk("reset.no_busy", 32'(rdy), 32'd1);

    // ADD 0xFFFF + 0x0001
    start_op(16'hFFFF, 16'h0001, 1'b0, 2'b00);
    wait_done(1'b0);
    chk("add.latency", 32'(lat),  32'd4);
    chk("add.busy",    32'(busy), 32'd4);
    chk("add.rdy",     32'(rdy),  32'd1);
    chk_res("add", 16'h0000, 1'b1, 1'b0, 1'b1, 1'b0);
    step();
    chk("add.done_pulse", 32'(done), 32'd0);
    chk("add.hold_sum",   32'(SUM),  32'h0000);

    // SUB 0x8000 - 0x0001
    start_op(16'h8000, 16'h0001, 1'b0, 2'b10);
    wait_done(1'b0);
    chk("sub.latency", 32'(lat), 32'd4);
    chk_res("sub", 16'h7FFF, 1'b1, 1'b1, 1'b0, 1'b0);

    // ADC 0x7FFF + 0x0000 + 1
    start_op(16'h7FFF, 16'h0000, 1'b1, 2'b01);
    wait_done(1'b0);
    chk_res("adc", 16'h8000, 1'b0, 1'b1, 1'b0, 1'b1);

    // SBB 0x0005 - 0x0005 - 1
    start_op(16'h0005, 16'h0005, 1'b1, 2'b11);
    wait_done(1'b0);
    chk_res("sbb", 16'hFFFF, 1'b0, 1'b0, 1'b0, 1'b1);
    idle_cycles(3);
    chk("sbb.hold_sum", 32'(SUM), 32'hFFFF);

    // Inputs disturbed and cs pulsed while busy: 0x1234 + 0x1111
    start_op(16'h1234, 16'h1111, 1'b0, 2'b00);
    wait_done(1'b1);
    chk("busy.latency", 32'(lat), 32'd4);
    chk_res("busy", 16'h2345, 1'b0, 1'b0, 1'b0, 1'b0);
    idle_cycles(6);
    chk("busy.single_done", 32'(ndone), 32'd0);
    chk("busy.rdy", 32'(rdy), 32'd1);

    // Back-to-back: 0x0F0F + 0x00F1, then SUB accepted on the done cycle
    start_op(16'h0F0F, 16'h00F1, 1'b0, 2'b00);
    wait_done(1'b0);
    chk_res("b2b1", 16'h1000, 1'b0, 1'b0, 1'b0, 1'b0);
    start_op(16'h1000, 16'h0001, 1'b0, 2'b10);
    chk("b2b2.accepted", 32'(rdy), 32'd0);
    wait_done(1'b0);
    chk("b2b2.latency", 32'(lat), 32'd4);
    chk_res("b2b2", 16'h0FFF, 1'b1, 1'b0, 1'b0, 1'b0);

    // Reset on the second busy cycle aborts the operation
    start_op(16'h1234, 16'h1111, 1'b0, 2'b00);
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("abort.rdy",  32'(rdy),  32'd1);
    chk("abort.done", 32'(done), 32'd0);
    chk_res("abort", 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0);
    idle_cycles(6);
    chk("abort.no_done", 32'(ndone), 32'd0);

    // Fresh operation after the abort: 0x0003 - 0x0005
    start_op(16'h0003, 16'h0005, 1'b0, 2'b10);
    wait_done(1'b0);
    chk("post.latency", 32'(lat), 32'd4);
    chk_res("post", 16'hFFFE, 1'b0, 1'b0, 1'b0, 1'b1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
